fdiv_issue_queue: RTL
=====================

Name: fdiv_issue_queue

Overview:
- Request front-end placed directly upstream of the Newton-Raphson single-precision divider (fdiv_newton).
- Buffers divide requests (operands, rounding mode, tag) in a small FIFO and issues them one at a time as a one-cycle start pulse, holding operands stable.
- Waits for the divider's valid, captures its result and returns it with the tag over a valid/ready result port.
- A watchdog converts a hung divide into a tagged error result.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, ≥2.
- TAG_W, 4, request tag width.
- TIMEOUT, 64, max WAIT cycles before error; ≥2.

Ports:
- clk  in  1  clock.
- clr  in  1  asynchronous active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  FIFO not full.
- in_a  in  32  dividend, IEEE-754 single.
- in_b  in  32  divisor, IEEE-754 single.
- in_rm  in  2  rounding mode.
- in_tag  in  TAG_W  request tag.
- div_a  out  32  to divider a.
- div_b  out  32  to divider b.
- div_rm  out  2  to divider rm.
- div_fdiv  out  1  one-cycle start pulse.
- div_ena  out  1  divider enable.
- div_valid  in  1  divider result valid.
- div_s  in  32  divider result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_s  out  32  quotient.
- res_tag  out  TAG_W  tag of result.
- res_err  out  1  result produced by timeout.
- q_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (clr high, async): FIFO empty; state IDLE; timeout counter 0; all outputs 0 except in_ready=1.
  - Zeroed outputs: div_a, div_b, div_rm, div_fdiv, div_ena, res_*, q_count.
  - Reset mid-operation drops queued and in-flight requests; a later div_valid for a dropped op is ignored.
- div_ena = 1 whenever clr low (registered; 0 during reset).
- FIFO:
  - Push on in_valid & in_ready.
  - in_ready = (q_count != DEPTH), combinational from registered count.
  - Pop only on the IDLE→START transition.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo DEPTH.
  - in_valid while full is ignored; no overwrite.
- FSM states:
  - IDLE: if q_count≠0, pop head into div_a/div_b/div_rm and the tag register → START.
  - START: div_fdiv=1 for exactly this cycle; operands already stable → WAIT. Timeout counter cleared.
  - WAIT:
    - div_fdiv=0. Each cycle, if div_valid=1: res_s←div_s, res_err←0 → DONE.
    - Else counter+1. When counter reaches TIMEOUT-1 without valid: res_s←32'h7FC00000, res_err←1 → DONE.
    - div_valid is ignored in IDLE, START and DONE.
  - DONE: res_valid=1; res_s/res_tag/res_err held stable. On res_ready=1 → IDLE; res_valid drops the next cycle.
- div_a/div_b/div_rm hold their values from pop until the next pop. They are never changed while in START/WAIT/DONE.
- Latency, empty queue, divider valid k cycles after the start pulse (k≥1):
  - Push accepted at edge E0.
  - START during cycle E1..E2 (div_fdiv high).
  - res_valid high from edge E2+k.
  - Back-to-back requests: ≥1 IDLE cycle between DONE acceptance and the next START.
- Results return in request order; only one divide is in flight.
- Sticky div_valid (level held from a previous op) must not satisfy a new op: require div_valid sampled in WAIT only. The divider drops valid on fdiv. If div_valid is still 1 on the first WAIT cycle, it is accepted; this is a documented divider contract.

Test Plan:
- Single op: push a=40C00000, b=40400000, rm=0, tag=3; divider model asserts valid 20 cycles after fdiv with s=40000000 → div_fdiv high exactly 1 cycle; res_valid with res_s=40000000, res_tag=3, res_err=0; q_count 1→0.
- Queue/backpressure, DEPTH=4, res_ready=0: push tags 0..4 back-to-back → in_ready low after 4 held entries (one popped into divider); tag 4 accepted only after a pop. Then results return as tags 0,1,2,3,4 in order with correct quotients (41200000/40800000 → 40200000).
- Timeout: divider model never asserts valid, TIMEOUT=64 → res_valid exactly 64 WAIT cycles after START with res_s=7FC00000, res_err=1; next request then proceeds normally.
- Result stall: hold res_ready=0 for 10 cycles in DONE → res_* stable, no new div_fdiv; res_ready=1 → next START two cycles later.
- Reset mid-WAIT with 2 queued: assert clr → all outputs zero, q_count=0, in_ready=1; a stale div_valid after release produces no res_valid.
- Real-divider integration with fdiv_newton: 42F6E979/40FC7AE1 → 417A5AB8; 0/40A00000 → 00000000; 7FC00000/40000000 → NaN (exponent FF, nonzero mantissa).

Source files
------------

// File: rtl/fdiv_issue_queue.sv
// fdiv_issue_queue: request front-end for the Newton-Raphson single-precision
// divider. Divide requests (operands, rounding mode, tag) are buffered in a
// small FIFO and issued one at a time. Each issue is a one-cycle start pulse,
// and the operands stay stable on the divider inputs until the next issue. The
// block waits for the divider's valid, captures the quotient and presents it
// with its tag on a valid/ready result port. A watchdog turns a hung divide
// into a tagged error result carrying a quiet NaN.
//
// Ports:
//   clk_i, clr_i        clock, asynchronous active-high reset
//   in_*                request port (valid/ready, a, b, rm, tag)
//   div_*               divider interface (a, b, rm, fdiv start pulse, ena,
//                       valid and s returned by the divider)
//   res_*               result port (valid/ready, s, tag, err)
//   q_count_o           FIFO occupancy
module fdiv_issue_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk_i,
  input  logic                     clr_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_a_i,
  input  logic [31:0]              in_b_i,
  input  logic [1:0]               in_rm_i,
  input  logic [TAG_W-1:0]         in_tag_i,
  output logic [31:0]              div_a_o,
  output logic [31:0]              div_b_o,
  output logic [1:0]               div_rm_o,
  output logic                     div_fdiv_o,
  output logic                     div_ena_o,
  input  logic                     div_valid_i,
  input  logic [31:0]              div_s_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [31:0]              res_s_o,
  output logic [TAG_W-1:0]         res_tag_o,
  output logic                     res_err_o,
  output logic [$clog2(DEPTH):0]   q_count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT);
  localparam int unsigned EntW = 66 + TAG_W;

  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [31:0]     QNaN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [EntW-1:0]   mem_q [DEPTH];
  logic [EntW-1:0]   head;
  logic              push, pop;

  logic [31:0]       div_a_q, div_b_q;
  logic [1:0]        div_rm_q;
  logic [TAG_W-1:0]  tag_q;
  logic              div_ena_q;
  logic [31:0]       res_s_q, res_s_d;
  logic              res_err_q, res_err_d;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  assign in_ready_o = (count_q != CntFull);
  assign push       = in_valid_i & in_ready_o;
  assign head       = mem_q[rd_ptr_q];

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_tag_i, in_rm_i, in_b_i, in_a_i};
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    pop       = 1'b0;
    res_s_d   = res_s_q;
    res_err_d = res_err_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // div_valid is only looked at here, so a level left over from an
        // earlier op (or one dropped by reset) cannot complete a new op.
        if (div_valid_i) begin
          res_s_d   = div_s_i;
          res_err_d = 1'b0;
          state_d   = StDone;
        end else if (tmo_q == TmoLast) begin
          res_s_d   = QNaN;
          res_err_d = 1'b1;
          state_d   = StDone;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDone: begin
        if (res_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      res_s_q   <= '0;
      res_err_q <= 1'b0;
      div_ena_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      res_s_q   <= res_s_d;
      res_err_q <= res_err_d;
      div_ena_q <= 1'b1;
    end
  end

  // Operands and tag load only on pop, so they are stable through
  // START/WAIT/DONE and the tag doubles as the result tag.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      div_a_q  <= '0;
      div_b_q  <= '0;
      div_rm_q <= '0;
      tag_q    <= '0;
    end else if (pop) begin
      {tag_q, div_rm_q, div_b_q, div_a_q} <= head;
    end
  end

  assign div_a_o     = div_a_q;
  assign div_b_o     = div_b_q;
  assign div_rm_o    = div_rm_q;
  assign div_fdiv_o  = (state_q == StStart);
  assign div_ena_o   = div_ena_q;
  assign res_valid_o = (state_q == StDone);
  assign res_s_o     = res_s_q;
  assign res_tag_o   = tag_q;
  assign res_err_o   = res_err_q;
  assign q_count_o   = count_q;

endmodule
